// File: rtl/data_axi_arb_if.sv
// AXI4 request/response payload types and the master-port bundle
// used between the requester arbiter and a single-beat AXI slave.
package data_axi_arb_pkg;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;
endpackage

interface data_axi_arb_if;
  import data_axi_arb_pkg::*;

  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);
endinterface

// File: rtl/data_axi_arb.sv
// Round-robin arbiter funnelling NUM_REQ core requesters onto one AXI master
// port, one single-beat transaction outstanding at a time.
module data_axi_arb
  import data_axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_REQ-1:0]              req_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [NUM_REQ-1:0]              err_o,
  input  logic [NUM_REQ-1:0]              write_en_i,
  input  logic [NUM_REQ-1:0][3:0]         byte_en_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ-1:0][31:0]        wdata_i,
  output logic [31:0]                     rdata_o,
  output s_axi_mosi_t                     m_axi_mosi,
  input  s_axi_miso_t                     m_axi_miso
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic                r_aw_done;
  logic                r_w_done;

  logic [IDX_W-1:0]    w_win;
  logic                w_any;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic [NUM_REQ-1:0]  w_owner_1h;
  logic                w_unused_miso;

  assign w_unused_miso = ^{m_axi_miso.bid, m_axi_miso.rid, m_axi_miso.rlast};

  // Scan from farthest to nearest so the last hit is the first requester after r_last.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (32'(r_last) + k) % NUM_REQ;
      if (req_i[IDX_W'(idx)]) begin
        w_win = IDX_W'(idx);
        w_any = 1'b1;
      end
    end
  end

  assign w_owner_1h = NUM_REQ'(1) << r_owner;
  assign w_aw_hs    = (r_state == WR_ADDR) && !r_aw_done && m_axi_miso.awready;
  assign w_w_hs     = (r_state == WR_ADDR) && !r_w_done  && m_axi_miso.wready;

  always_ff @(posedge clk) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_next = write_en_i[w_win] ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        if (m_axi_miso.arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        if (m_axi_miso.rvalid) w_next = IDLE;
      end
      WR_ADDR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_miso.bvalid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so an in-flight transaction vanishes immediately.
  always_comb begin
    m_axi_mosi = '0;
    gnt_o      = '0;
    rvalid_o   = '0;
    err_o      = '0;
    rdata_o    = '0;
    if (arst_n) begin
      unique case (r_state)
        RD_ADDR: begin
          m_axi_mosi.arvalid = 1'b1;
          m_axi_mosi.araddr  = AXI_ADDR_W'(r_addr);
          m_axi_mosi.arlen   = 8'd0;
          m_axi_mosi.arsize  = AXI_SIZE_4B;
          m_axi_mosi.arburst = AXI_BURST_INCR;
          if (m_axi_miso.arready) gnt_o = w_owner_1h;
        end
        RD_DATA: begin
          m_axi_mosi.rready = 1'b1;
          if (m_axi_miso.rvalid) begin
            rvalid_o = w_owner_1h;
            rdata_o  = m_axi_miso.rdata;
            if (m_axi_miso.rresp != AXI_RESP_OKAY) err_o = w_owner_1h;
          end
        end
        WR_ADDR: begin
          if (!r_aw_done) begin
            m_axi_mosi.awvalid = 1'b1;
            m_axi_mosi.awaddr  = AXI_ADDR_W'(r_addr);
            m_axi_mosi.awlen   = 8'd0;
            m_axi_mosi.awsize  = AXI_SIZE_4B;
            m_axi_mosi.awburst = AXI_BURST_INCR;
          end
          if (!r_w_done) begin
            m_axi_mosi.wvalid = 1'b1;
            m_axi_mosi.wdata  = r_wdata;
            m_axi_mosi.wstrb  = r_be;
            m_axi_mosi.wlast  = 1'b1;
          end
          if (w_aw_hs) gnt_o = w_owner_1h;
        end
        WR_RESP: begin
          m_axi_mosi.bready = 1'b1;
          if (m_axi_miso.bvalid) begin
            rvalid_o = w_owner_1h;
            if (m_axi_miso.bresp != AXI_RESP_OKAY) err_o = w_owner_1h;
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture, round-robin pointer and write-channel completion flags.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_owner   <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_last    <= w_win;
        r_owner   <= w_win;
        r_addr    <= addr_i[w_win];
        r_write   <= write_en_i[w_win];
        r_be      <= byte_en_i[w_win];
        r_wdata   <= wdata_i[w_win];
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  logic w_unused_write;
  assign w_unused_write = r_write;

endmodule

// File: doc/data_axi_arb.md
DATA_AXI_ARB -- requirements
Module: data_axi_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of core-side requesters sharing one AXI master port (legal 2..4).
REQ-002 SHALL have parameter ADDR_W, default 32, address width of core-side addr_i.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports, in this order:
- clk  input  1  clock, all state on rising edge
- arst_n  input  1  synchronous active-low reset
- req_i  input  NUM_REQ  per-requester transfer request
- gnt_o  output  NUM_REQ  per-requester address accepted
- rvalid_o  output  NUM_REQ  per-requester transfer complete (read data or write response)
- err_o  output  NUM_REQ  per-requester error, qualified by rvalid_o
- write_en_i  input  NUM_REQ  1 = write, 0 = read
- byte_en_i  input  NUM_REQ x 4  write byte strobes
- addr_i  input  NUM_REQ x ADDR_W  byte address
- wdata_i  input  NUM_REQ x 32  write data
- rdata_o  output  32  read data, valid with owner's rvalid_o
- m_axi_mosi  output  s_axi_mosi_t  AXI master request bundle
- m_axi_miso  input  s_axi_miso_t  AXI master response bundle

Function
REQ-005 SHALL keep at most one AXI transaction outstanding; every transaction is single-beat: len 0, size 2, burst INCR, id 0.
REQ-006 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
REQ-007 SHALL arbitrate in IDLE round-robin: winner is first asserted req_i after last_owner, searching upward with wrap; last_owner updates on every grant.
REQ-008 SHALL, in IDLE with any req_i high, latch winner index, addr, write_en, byte_en, wdata and move to RD_ADDR (read) or WR_ADDR (write) the next cycle; gnt_o stays 0 in IDLE.
REQ-009 SHALL, in RD_ADDR, drive arvalid=1 and araddr=latched addr, holding stable until arready; on arready: gnt_o[owner]=1 for that cycle only, go to RD_DATA.
REQ-010 SHALL, in RD_DATA, drive rready=1; on rvalid: rvalid_o[owner]=1, rdata_o=rdata, err_o[owner]=(rresp!=OKAY), all for that cycle only; go to IDLE.
REQ-011 SHALL, in WR_ADDR, drive awvalid and wvalid together from latched values, tracking aw_done/w_done flags; each valid drops after its own handshake; gnt_o[owner]=1 in the cycle awready is seen; go to WR_RESP once both are done, including same-cycle completion.
REQ-012 SHALL, in WR_RESP, drive bready=1; on bvalid: rvalid_o[owner]=1, err_o[owner]=(bresp!=OKAY) for one cycle; go to IDLE.
REQ-013 SHALL drive rdata_o=0 and all mosi fields not listed above to 0 when not in use; rvalid_o, gnt_o and err_o SHALL be one-hot or zero.
REQ-014 SHALL ignore requester inputs after latching; a requester dropping req_i mid-transaction does not abort it.
REQ-015 SHALL give minimum read latency of 3 cycles from req_i to rvalid_o with zero-wait slave (IDLE, RD_ADDR, RD_DATA).
REQ-016 SHALL, with a requester held high back-to-back while another is waiting, alternate grants (no starvation, bound NUM_REQ-1 transactions).

Reset
REQ-017 SHALL, while arst_n=0 at a clock edge, go to IDLE, set last_owner=NUM_REQ-1, and clear aw_done, w_done and latched data; all outputs are 0 the cycle after.
REQ-018 SHALL, on reset mid-transaction, drop all valids immediately with no completion reported to any requester.

Verification
REQ-019 Single read: req_i=01, addr 0x100, slave rdata 0xDEADBEEF zero-wait -> gnt_o[0] in cycle 1, rvalid_o[0] with rdata_o 0xDEADBEEF in cycle 2, err_o=0.
REQ-020 Simultaneous req_i=11 after reset, both reads -> requester 0 served first, then requester 1; second arvalid follows first rvalid by 1 cycle.
REQ-021 Write, awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, gnt_o[1] on awready, rvalid_o[1] on bvalid.
REQ-022 Write with bresp=SLVERR -> rvalid_o[owner]=1 and err_o[owner]=1 same cycle; next transaction proceeds normally.
REQ-023 arst_n low during RD_DATA -> next cycle all outputs 0, state IDLE; a later rvalid from slave produces no rvalid_o.
REQ-024 Requester 0 continuously requesting, requester 1 raises req -> requester 1 granted after at most one further requester-0 transaction.
